// File: rtl/mem_stage_pkg.sv
// Shared LC-3b types for the memory-access stage: memory op field,
// stage state encoding and the control word that carries mem_op.
package mem_stage_pkg;

   typedef enum logic [2:0] {
      mem_none,
      mem_ldr,
      mem_str,
      mem_ldb,
      mem_stb,
      mem_ldi,
      mem_sti
   } lc3b_mem_op;

   typedef enum logic [1:0] {
      IDLE,
      INDIRECT,
      DONE
   } lc3b_mem_state;

   typedef struct packed {
      logic [3:0] opcode;
      logic       load_regfile;
      logic       load_cc;
      lc3b_mem_op mem_op;
   } lc3b_control;

   localparam int CONTROL_WIDTH = $bits(lc3b_control);

   // A squashed bubble must never touch memory, so its mem_op is mem_none.
   localparam lc3b_control SQUASH_CONTROL = '{
      opcode:       4'b0000,
      load_regfile: 1'b0,
      load_cc:      1'b0,
      mem_op:       mem_none
   };

   function automatic logic isIndirect(input lc3b_mem_op op);
      return (op == mem_ldi) || (op == mem_sti);
   endfunction

   function automatic logic isStore(input lc3b_mem_op op);
      return (op == mem_str) || (op == mem_stb);
   endfunction

endpackage

// File: rtl/mem_format.sv
// Combinational address/data formatting for the first memory access:
// byte select with sign extension on loads, lane replication on stores.
import mem_stage_pkg::*;

module mem_format (
   input  lc3b_mem_op  memOp_i,
   input  logic [15:0] aluIn_i,
   input  logic [15:0] sr2In_i,
   input  logic [15:0] rdata_i,
   output logic [15:0] addr_o,
   output logic [15:0] wdata_o,
   output logic [1:0]  byteEn_o,
   output logic [15:0] loadData_o
);

   logic [7:0] selByte;

   always_comb begin
      addr_o     = aluIn_i & 16'hFFFE;
      wdata_o    = sr2In_i;
      byteEn_o   = 2'b11;
      selByte    = aluIn_i[0] ? rdata_i[15:8] : rdata_i[7:0];
      loadData_o = rdata_i;
      if (memOp_i == mem_ldb) begin
         addr_o     = aluIn_i;
         loadData_o = {{8{selByte[7]}}, selByte};
      end
      if (memOp_i == mem_stb) begin
         addr_o   = aluIn_i;
         wdata_o  = {sr2In_i[7:0], sr2In_i[7:0]};
         byteEn_o = aluIn_i[0] ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory-access stage: issues data-memory requests, handles the
// two-access indirect ops and stalls the pipeline until the op completes.
import mem_stage_pkg::*;

module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  lc3b_mem_op  mem_op,
   input  logic [15:0] ALU_in,
   input  logic [15:0] sr2_in,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic [15:0] dmem_address,
   output logic [15:0] dmem_wdata,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [1:0]  dmem_byte_enable,
   output logic [15:0] mem_data_out,
   output logic        mem_done,
   output logic        stall_pipeline
);

   lc3b_mem_state state_q, state_d;
   logic [15:0]   mdr_q, mdr_d;
   logic [15:0]   ptr_q, ptr_d;

   logic [15:0] fmtAddr;
   logic [15:0] fmtWdata;
   logic [1:0]  fmtByteEn;
   logic [15:0] fmtLoad;

   mem_format u_format (
      .memOp_i    (mem_op),
      .aluIn_i    (ALU_in),
      .sr2In_i    (sr2_in),
      .rdata_i    (dmem_rdata),
      .addr_o     (fmtAddr),
      .wdata_o    (fmtWdata),
      .byteEn_o   (fmtByteEn),
      .loadData_o (fmtLoad)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mdr_q   <= 16'h0000;
         ptr_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         mdr_q   <= mdr_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mdr_d   = mdr_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (mem_op != mem_none && dmem_resp) begin
               if (isIndirect(mem_op)) begin
                  ptr_d   = dmem_rdata;
                  state_d = INDIRECT;
               end else begin
                  if (!isStore(mem_op)) mdr_d = fmtLoad;
                  state_d = DONE;
               end
            end
         end
         INDIRECT: begin
            if (dmem_resp) begin
               if (mem_op == mem_ldi) mdr_d = dmem_rdata;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Reset overrides the request strobes so an aborted access cannot leak out.
   always_comb begin
      dmem_address     = 16'h0000;
      dmem_wdata       = 16'h0000;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = 2'b00;
      mem_done         = 1'b0;
      stall_pipeline   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op != mem_none) begin
               dmem_address   = fmtAddr;
               stall_pipeline = 1'b1;
               if (isStore(mem_op)) begin
                  dmem_write       = 1'b1;
                  dmem_wdata       = fmtWdata;
                  dmem_byte_enable = fmtByteEn;
               end else begin
                  dmem_read = 1'b1;
               end
            end
         end
         INDIRECT: begin
            dmem_address   = ptr_q & 16'hFFFE;
            stall_pipeline = 1'b1;
            if (mem_op == mem_sti) begin
               dmem_write       = 1'b1;
               dmem_wdata       = sr2_in;
               dmem_byte_enable = 2'b11;
            end else begin
               dmem_read = 1'b1;
            end
         end
         DONE:    mem_done = 1'b1;
         default: ;
      endcase
      if (reset) begin
         dmem_read        = 1'b0;
         dmem_write       = 1'b0;
         dmem_byte_enable = 2'b00;
      end
   end

   assign mem_data_out = mdr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized check of mem_stage against a behavioural
// model of each memory op and a bench-driven variable-latency memory.
import mem_stage_pkg::*;

module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   lc3b_mem_op  mem_op;
   logic [15:0] ALU_in, sr2_in, dmem_rdata;
   logic        dmem_resp;
   logic [15:0] dmem_address, dmem_wdata, mem_data_out;
   logic        dmem_read, dmem_write, mem_done, stall_pipeline;
   logic [1:0]  dmem_byte_enable;

   int total = 0;
   int bad   = 0;
   logic [15:0] expMdr;

   mem_stage dut (
      .clk              (clk),
      .reset            (reset),
      .mem_op           (mem_op),
      .ALU_in           (ALU_in),
      .sr2_in           (sr2_in),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .mem_data_out     (mem_data_out),
      .mem_done         (mem_done),
      .stall_pipeline   (stall_pipeline)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access phase as seen on the memory bus, held for waits+1 cycles.
   task automatic busPhase(input string tag, input int waits, input logic [15:0] rdata,
                           input logic expRd, input logic [15:0] expAddr,
                           input logic [15:0] expWd, input logic [1:0] expBe);
      for (int c = 0; c <= waits; c++) begin
         if (c == waits) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
         end else begin
            dmem_rdata = 16'($urandom);
         end
         #1;
         checkOutput({tag, ".read"},  16'(dmem_read), 16'(expRd));
         checkOutput({tag, ".write"}, 16'(dmem_write), 16'(!expRd));
         checkOutput({tag, ".addr"},  dmem_address, expAddr);
         checkOutput({tag, ".be"},    16'(dmem_byte_enable), expRd ? 16'h0 : 16'(expBe));
         if (!expRd) checkOutput({tag, ".wdata"}, dmem_wdata, expWd);
         checkOutput({tag, ".stall"}, 16'(stall_pipeline), 16'h1);
         checkOutput({tag, ".done"},  16'(mem_done), 16'h0);
         @(negedge clk);
         dmem_resp = 1'b0;
      end
   endtask

   // Drives one complete memory op from IDLE through DONE; expects to start at a negedge.
   task automatic applyStimulus(input lc3b_mem_op op, input logic [15:0] alu, input logic [15:0] sr2,
                                input int w1, input logic [15:0] r1,
                                input int w2, input logic [15:0] r2);
      string tag;
      logic byteOp, store, indirect, rd1;
      logic [15:0] addr1, wd1;
      logic [1:0]  be1;
      logic [7:0]  b;
      tag      = op.name();
      byteOp   = (op == mem_ldb) || (op == mem_stb);
      store    = (op == mem_str) || (op == mem_stb);
      indirect = (op == mem_ldi) || (op == mem_sti);
      rd1      = !store;
      addr1    = byteOp ? alu : {alu[15:1], 1'b0};
      wd1      = (op == mem_stb) ? {sr2[7:0], sr2[7:0]} : sr2;
      be1      = (op == mem_stb) ? (alu[0] ? 2'b10 : 2'b01) : 2'b11;

      mem_op = op; ALU_in = alu; sr2_in = sr2; dmem_resp = 1'b0;
      busPhase({tag, ".a1"}, w1, r1, rd1, addr1, wd1, be1);
      if (indirect)
         busPhase({tag, ".a2"}, w2, r2, op == mem_ldi, {r1[15:1], 1'b0}, sr2, 2'b11);

      if (op == mem_ldr) expMdr = r1;
      if (op == mem_ldi) expMdr = r2;
      if (op == mem_ldb) begin
         b = alu[0] ? r1[15:8] : r1[7:0];
         expMdr = (b >= 8'd128) ? (16'hFF00 | 16'(b)) : 16'(b);
      end
      #1;
      checkOutput({tag, ".done"},  16'(mem_done), 16'h1);
      checkOutput({tag, ".dstall"}, 16'(stall_pipeline), 16'h0);
      checkOutput({tag, ".dreq"},  16'({dmem_read, dmem_write}), 16'h0);
      checkOutput({tag, ".dbe"},   16'(dmem_byte_enable), 16'h0);
      checkOutput({tag, ".data"},  mem_data_out, expMdr);
      @(negedge clk);
      mem_op = mem_none;
   endtask

   initial begin
      reset = 1'b1; mem_op = mem_none; ALU_in = 16'h0; sr2_in = 16'h0;
      dmem_rdata = 16'h0; dmem_resp = 1'b0; expMdr = 16'h0;
      @(negedge clk); @(negedge clk);
      #1;
      checkOutput("rst.data",  mem_data_out, 16'h0);
      checkOutput("rst.done",  16'(mem_done), 16'h0);
      checkOutput("rst.req",   16'({dmem_read, dmem_write}), 16'h0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] idle with spurious resp");
      mem_op = mem_none; ALU_in = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         dmem_resp = (i != 1); dmem_rdata = 16'hDEAD;
         #1;
         checkOutput("idle.req",   16'({dmem_read, dmem_write}), 16'h0);
         checkOutput("idle.stall", 16'(stall_pipeline), 16'h0);
         checkOutput("idle.done",  16'(mem_done), 16'h0);
         @(negedge clk);
      end
      dmem_resp = 1'b0;

      $display("[TB] directed ops");
      applyStimulus(mem_ldr, 16'h3005, 16'h0000, 2, 16'h1234, 0, 16'h0);
      applyStimulus(mem_ldb, 16'h2001, 16'h0000, 0, 16'h80AA, 0, 16'h0);
      applyStimulus(mem_ldb, 16'h2000, 16'h0000, 1, 16'h80AA, 0, 16'h0);
      applyStimulus(mem_ldb, 16'h2001, 16'h0000, 0, 16'h7F11, 0, 16'h0);
      applyStimulus(mem_stb, 16'h4003, 16'hBEEF, 1, 16'h0000, 0, 16'h0);
      applyStimulus(mem_stb, 16'h4002, 16'hBE12, 0, 16'h0000, 0, 16'h0);
      applyStimulus(mem_str, 16'h4003, 16'hA5C3, 0, 16'h0000, 0, 16'h0);
      applyStimulus(mem_ldi, 16'h5000, 16'h0000, 0, 16'h6001, 0, 16'hCAFE);
      applyStimulus(mem_sti, 16'h5000, 16'h1357, 0, 16'h6001, 0, 16'h0);
      applyStimulus(mem_ldi, 16'h5001, 16'h0000, 2, 16'h7003, 3, 16'h8421);

      $display("[TB] reset during indirect");
      mem_op = mem_ldi; ALU_in = 16'h5000; dmem_resp = 1'b1; dmem_rdata = 16'h6001;
      #1;
      checkOutput("rsti.a1read", 16'(dmem_read), 16'h1);
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      checkOutput("rsti.a2addr", dmem_address, 16'h6000);
      checkOutput("rsti.a2read", 16'(dmem_read), 16'h1);
      reset = 1'b1;
      #1;
      checkOutput("rsti.rstreq", 16'({dmem_read, dmem_write}), 16'h0);
      checkOutput("rsti.rstbe",  16'(dmem_byte_enable), 16'h0);
      @(negedge clk);
      reset = 1'b0; mem_op = mem_none; dmem_resp = 1'b1; dmem_rdata = 16'hBBBB;
      expMdr = 16'h0;
      #1;
      checkOutput("rsti.stall", 16'(stall_pipeline), 16'h0);
      checkOutput("rsti.req",   16'({dmem_read, dmem_write}), 16'h0);
      checkOutput("rsti.data",  mem_data_out, 16'h0);
      checkOutput("rsti.done",  16'(mem_done), 16'h0);
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      checkOutput("rsti.late.done",  16'(mem_done), 16'h0);
      checkOutput("rsti.late.stall", 16'(stall_pipeline), 16'h0);
      @(negedge clk);
      applyStimulus(mem_ldr, 16'h0102, 16'h0, 0, 16'h4321, 0, 16'h0);

      $display("[TB] randomized ops");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(lc3b_mem_op'($urandom_range(1, 6)), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)), 16'($urandom),
                       int'($urandom_range(0, 3)), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
